edge_event_waiter: RTL
======================

Name: edge_event_waiter

Overview:
Synchronous edge-event stage that consumes a toggling level signal, such as a clock-derived or inverted-clock net.
- Synchronizes the signal to clk and produces single-cycle rise/fall pulses.
- Implements a start/done "wait for N edges of type T" service, which is the hardware equivalent of a blocking @(posedge x) / @(negedge x) / @x event control.
- Sits downstream of the signal source and feeds sequencing logic that must stall until a given number of edges has occurred.

Parameters:
CNT_W, 8, width of the requested edge count and of edges_seen
SYNC_STAGES, 2, synchronizer flop depth on sig_in (legal range 2..4)
TIMEOUT_CYCLES, 1000, cycles in WAIT before timeout; used only with the optional feature

Ports:
clk  input  1  single clock; all state updates on posedge clk
rst  input  1  asynchronous, active-high reset
sig_in  input  1  monitored level, asynchronous to clk
start  input  1  request a wait; accepted only in IDLE
mode  input  2  edge type: 00 any edge, 01 rising, 10 falling, 11 any edge
count  input  CNT_W  number of qualifying edges to wait for
busy  output  1  high while in WAIT or DONE
done  output  1  one-cycle pulse when the requested count is reached
rise_pulse  output  1  one-cycle pulse per synchronized rising edge
fall_pulse  output  1  one-cycle pulse per synchronized falling edge
level  output  1  synchronized sig_in (last synchronizer stage)
edges_seen  output  CNT_W  qualifying edges counted in the current or last wait
timeout  output  1  one-cycle timeout pulse; tied 0 when the optional feature is compiled out

Behaviour:
Synchronizer and edge detector
- SYNC_STAGES flops feed level; prev flop holds level delayed by one cycle.
- rise_pulse = level & ~prev; fall_pulse = ~level & prev. Both are decoded from flops only.
- A sig_in transition sampled at edge k appears on level after edge k+SYNC_STAGES-1. The matching pulse is high for exactly that one cycle.
- All synchronizer flops and prev reset to 0. If sig_in is 1 out of reset, the first time level goes high it is a rising edge and pulses rise_pulse.

Reset (asynchronous, active-high)
- State goes to IDLE.
- busy=0, done=0, timeout=0, edges_seen=0, level=0, rise_pulse=0, fall_pulse=0.
- Asserting rst mid-wait aborts the wait immediately; done is never generated for the aborted wait.

State machine: IDLE, WAIT, DONE
- IDLE:
  - start=1 latches mode and count, clears edges_seen to 0, and enters WAIT.
  - An edge pulse in the acceptance cycle is not counted.
  - If count==0, go to DONE directly (done one cycle after acceptance).
- WAIT:
  - Each cycle with a qualifying pulse increments edges_seen.
  - Qualifying pulse: rise|fall for mode 00/11, rise for 01, fall for 10.
  - When the increment makes edges_seen equal the latched count, go to DONE.
  - start is ignored.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - edges_seen holds its final value until the next accepted start.
  - start in DONE is ignored; a new start is accepted in IDLE on the following cycle.
- Latency: done is asserted the cycle after the pulse that completes the count.

Arithmetic
- edges_seen never exceeds the latched count, so it cannot wrap.
- count = 2^CNT_W-1 is legal.

Outputs
- busy = (state != IDLE).
- rise_pulse, fall_pulse and level are independent of state and run continuously.

Optional Feature:
Macro: EDGE_WAIT_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES before the count completes, go to IDLE with timeout=1 for one cycle; done is not asserted.
  - If completion and timeout occur in the same cycle, completion wins: done=1, timeout=0.
  - count==0 never times out.
- Undefined: no counter is built, timeout is tied 0, and WAIT lasts indefinitely.

Test Plan:
- Reset with sig_in=1, SYNC_STAGES=2 -> one rise_pulse two cycles after rst deasserts; busy=0; edges_seen=0.
- start, mode=00, count=2, sig_in toggled every 5 cycles -> edges_seen steps 1,2; single done the cycle after the 2nd pulse; busy drops with done.
- mode=10, count=2, four toggles starting from low -> rises ignored; done after the 2nd fall; edges_seen=2.
- count=0 start -> done one cycle after acceptance, no edges needed; start pulsed during DONE is ignored and then accepted in IDLE.
- rst asserted mid-WAIT (mode=01, count=5, edges_seen=3) -> immediately busy=0, edges_seen=0; no done after rst deasserts.
- With EDGE_WAIT_TIMEOUT_EN, TIMEOUT_CYCLES=20, sig_in held low -> timeout pulse 20 cycles after entry to WAIT, done never asserted; without the macro, busy stays 1 for 200 cycles.

Source files
------------

// File: rtl/edge_event_waiter.sv
// Edge-event stage: synchronizes sig_in, emits rise/fall pulses, and runs a "wait for N edges" start/done service.
// Optional watchdog on the wait is enabled by defining EDGE_WAIT_TIMEOUT_EN.
module edge_event_waiter #(
  parameter int CNT_W          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             level,
  output logic [CNT_W-1:0] edges_seen,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("edge_event_waiter: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  state_t           state;
  state_t           state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic             prev;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] count_q;
  logic             qual;
  logic             hit;
  logic             complete;
  logic             expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level      = sync[SYNC_STAGES-1];
  assign rise_pulse = level & ~prev;
  assign fall_pulse = ~level & prev;

  always_comb begin
    qual = rise_pulse | fall_pulse;
    case (mode_q)
      2'b01:   qual = rise_pulse;
      2'b10:   qual = fall_pulse;
      default: qual = rise_pulse | fall_pulse;
    endcase
  end

  // edges_seen stays below count_q while waiting, so the +1 compare cannot wrap
  assign hit      = (state == WAIT) && qual;
  assign complete = hit && ((edges_seen + CNT_W'(1)) == count_q);

`ifdef EDGE_WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cycles;

  assign expire = (state == WAIT) && (wait_cycles == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cycles <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= expire && !complete;
      if (state == WAIT)
        wait_cycles <= wait_cycles + TW'(1);
      else
        wait_cycles <= '0;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start)
          state_next = (count == '0) ? DONE : WAIT;
      end
      WAIT: begin
        if (complete)
          state_next = DONE;
        else if (expire)
          state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pulse in the acceptance cycle is deliberately dropped: only hits seen in WAIT count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= 2'b00;
      count_q    <= '0;
      edges_seen <= '0;
    end else if ((state == IDLE) && start) begin
      mode_q     <= mode;
      count_q    <= count;
      edges_seen <= '0;
    end else if (hit) begin
      edges_seen <= edges_seen + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
